// File: rtl/nios_system_switch_ctrl_pkg.sv
// Shared constants for the slide-switch Avalon-MM controller.
package nios_system_switch_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  localparam int unsigned TICK_RESET_DEF = 50000;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/nios_system_switch_debounce.sv
// One switch bit: counts consecutive disagreeing samples and accepts a new level.
module nios_system_switch_debounce #(
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_load,
  input  logic i_sync_bit,
  output logic o_level
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_SAMPLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Sample on tick: load directly during INIT, else require a stable run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (i_tick) begin
      if (i_load) begin
        r_level <= i_sync_bit;
        r_cnt   <= '0;
      end else if (i_sync_bit == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= i_sync_bit;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/nios_system_switch_ctrl.sv
// Slide-switch PIO slave: synchronizer, prescaled debounce, edge capture, maskable irq.
module nios_system_switch_ctrl
  import nios_system_switch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 18,
  parameter int unsigned TICK_WIDTH     = 16,
  parameter int unsigned TICK_RESET     = TICK_RESET_DEF,
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq,
  input  logic [DATA_WIDTH-1:0] in_port
);

  localparam int unsigned ICNT_W = 3;
  localparam logic [ICNT_W-1:0] INIT_LAST = ICNT_W'(STABLE_SAMPLES - 1);

  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_sync;
  logic [TICK_WIDTH-1:0] r_presc;
  logic [TICK_WIDTH-1:0] r_period;
  logic [ICNT_W-1:0]     r_init_cnt;
  state_e                r_state;
  logic                  r_cap_en;
  logic [DATA_WIDTH-1:0] r_deb_d;
  logic [DATA_WIDTH-1:0] r_edge;
  logic [DATA_WIDTH-1:0] r_mask;

  logic                  w_wr;
  logic [TICK_WIDTH-1:0] w_period_eff;
  logic                  w_tick;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_deb;
  logic [DATA_WIDTH-1:0] w_set;
  logic [DATA_WIDTH-1:0] w_clr;
  logic                  w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_period_eff   = (r_period == '0) ? TICK_WIDTH'(1) : r_period;
  assign w_tick         = (r_presc == (w_period_eff - TICK_WIDTH'(1)));
  assign w_load         = (r_state == ST_INIT);
  assign w_set          = r_cap_en ? (w_deb ^ r_deb_d) : '0;
  assign w_clr          = (w_wr && address == ADDR_EDGE) ? writedata[DATA_WIDTH-1:0] : '0;
  assign w_unused_wdata = &{1'b0, writedata[31:DATA_WIDTH]};
  assign irq            = |(r_edge & r_mask);

  // Two-flop synchronizer on the raw switch pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync  <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync  <= r_sync1;
    end
  end

  // Debounce prescaler; a period write restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_wr && address == ADDR_PERIOD) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + TICK_WIDTH'(1);
    end
  end

  // INIT absorbs the power-up levels for a few ticks, then RUN forever.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_cap_en   <= 1'b0;
    end else begin
      r_cap_en <= (r_state == ST_RUN);
      if (r_state == ST_INIT && w_tick) begin
        if (r_init_cnt == INIT_LAST) begin
          r_state    <= ST_RUN;
          r_init_cnt <= '0;
        end else begin
          r_init_cnt <= r_init_cnt + ICNT_W'(1);
        end
      end
    end
  end

  // Per-bit debounce instances.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_deb
    nios_system_switch_debounce #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_deb (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_tick     (w_tick),
      .i_load     (w_load),
      .i_sync_bit (r_sync[gi]),
      .o_level    (w_deb[gi])
    );
  end

  // Software registers: mask, period, and edge capture where set beats clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb_d  <= '0;
      r_edge   <= '0;
      r_mask   <= '0;
      r_period <= TICK_WIDTH'(TICK_RESET);
    end else begin
      r_deb_d <= w_deb;
      r_edge  <= (r_edge & ~w_clr) | w_set;
      if (w_wr && address == ADDR_MASK) begin
        r_mask <= writedata[DATA_WIDTH-1:0];
      end
      if (w_wr && address == ADDR_PERIOD) begin
        r_period <= writedata[TICK_WIDTH-1:0];
      end
    end
  end

  // Read mux registered every cycle for 1-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_DATA: readdata <= 32'(w_deb);
        ADDR_MASK: readdata <= 32'(r_mask);
        ADDR_EDGE: readdata <= 32'(r_edge);
        default:   readdata <= 32'(r_period);
      endcase
    end
  end

endmodule
